// File: rtl/mem_align_pkg.sv
// Shared encodings for the MEM-stage alignment unit: access sizes, FSM states
// and the size/address legality rule used by the request path.
package mem_align_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Size 11 is never legal; halves need an even address, words a 4-byte one.
    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lane[0];
            SZ_WORD: ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load-path lane extraction: picks the addressed byte/half out of the read word
// and sign- or zero-fills it back to 32 bits. Word loads pass straight through.
module load_extend
    import mem_align_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        case (i_size)
            SZ_BYTE: o_data = {{24{i_sign & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_sign & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// MEM-stage data-memory front end: store lane placement with byte enables, load
// extraction/extension, and a two-state FSM stalling the pipeline on wait-states.
module mem_align_unit
    import mem_align_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rdata_out,
    output logic              rdata_valid,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              o_dbg_state
);

    state_e            r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_rdata;
    logic              r_rdata_valid;
    logic              r_misalign;
    logic [1:0]        r_ld_lane;
    logic [1:0]        r_ld_size;
    logic              r_ld_sign;

    logic              w_legal;
    logic              w_accept;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ext;

    assign w_legal  = is_legal(req_size, req_addr[1:0]);
    assign w_accept = (r_state == ST_IDLE) && req_valid && w_legal;
    assign stall    = w_accept || ((r_state == ST_BUSY) && !mem_ack);

    always_comb begin
        case (req_size)
            SZ_BYTE: begin
                w_wdata = {4{req_wdata[7:0]}};
                w_be    = 4'b0001 << req_addr[1:0];
            end
            SZ_HALF: begin
                w_wdata = {2{req_wdata[15:0]}};
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = req_wdata;
                w_be    = 4'b1111;
            end
        endcase
    end

    // Lane/size/sign are captured at accept so the EX stage may move on at the ack edge.
    load_extend u_load_extend (
        .i_word (mem_rdata),
        .i_addr (r_ld_lane),
        .i_size (r_ld_size),
        .i_sign (r_ld_sign),
        .o_data (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_be      <= 4'b0000;
            r_mem_wdata   <= 32'h0;
            r_rdata       <= 32'h0;
            r_rdata_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_ld_lane     <= 2'b00;
            r_ld_size     <= SZ_BYTE;
            r_ld_sign     <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_misalign    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && w_legal) begin
                        r_state     <= ST_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= req_we;
                        r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_wdata;
                        r_ld_lane   <= req_addr[1:0];
                        r_ld_size   <= req_size;
                        r_ld_sign   <= req_sign;
                    end else if (req_valid) begin
                        r_misalign  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_rdata       <= w_ext;
                            r_rdata_valid <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_be      = r_mem_be;
    assign mem_wdata   = r_mem_wdata;
    assign rdata_out   = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign misalign    = r_misalign;
    assign o_dbg_state = r_state;

endmodule

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
MEM-stage data-memory front end for the pipelined CPU. This is the narrowing/lane-placement counterpart of the immediate extender.
- Store path: narrows 32-bit register data to byte/half lanes and generates byte enables.
- Load path: extracts the addressed lane, then sign- or zero-extends it back to 32 bits.
- A small FSM handles memory wait-states and stalls the pipeline until the memory acknowledges.

Parameters:
ADDR_W, 32, byte-address width of the request and memory address ports.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  MEM stage holds a load/store; held stable while stall=1
req_we  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_sign  in  1  load extension: 1=sign-extend, 0=zero-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (low bits significant for byte/half)
stall  out  1  freeze PC/IF/ID/EX/MEM registers
rdata_out  out  32  extended load result
rdata_valid  out  1  one-cycle pulse, rdata_out valid
misalign  out  1  one-cycle pulse on illegal size or misaligned address
mem_req  out  1  memory access request
mem_we  out  1  memory write
mem_addr  out  ADDR_W  word-aligned address, {req_addr[ADDR_W-1:2],2'b00}
mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory completes access this cycle
mem_rdata  in  32  read word, valid when mem_ack=1

Behaviour:
- Reset values: state=IDLE; mem_req, mem_we, mem_be, mem_wdata, mem_addr, rdata_out, rdata_valid, misalign all 0.
- Alignment check:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Size 11 is always illegal.
- IDLE, req_valid=1, illegal or misaligned: registered misalign=1 for one cycle; no memory access; stall=0; state stays IDLE.
- IDLE, req_valid=1, legal: stall=1 combinationally. At the clock edge, latch mem_* from the request and go to BUSY (mem_req=1).
- BUSY: mem_req, mem_we, mem_addr, mem_be, mem_wdata are held constant.
  - stall = ~mem_ack.
  - On mem_ack=1 (may come in the first BUSY cycle): next state IDLE; mem_req=0 next cycle.
  - Load with ack: rdata_out <= extended lane; rdata_valid=1 for the following cycle only.
  - Store with ack: rdata_valid stays 0.
- Minimum latency: request cycle plus one BUSY cycle, i.e. 1 stall cycle. Each extra wait-state adds one stall cycle.
- Store lane placement:
  - Byte: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - Half: wdata={2{d[15:0]}}, be=addr[1]?1100:0011.
  - Word: wdata=d, be=1111.
- Load extraction:
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (bits 31:16 when 1).
  - Fill bits 31:8 or 31:16 with the lane MSB if req_sign=1, else 0.
  - Word loads ignore req_sign.
- mem_ack while IDLE is ignored.
- Back-to-back requests: a new request is accepted in the IDLE cycle immediately after an ack.
- rst in BUSY: next cycle is IDLE with mem_req=0, stall=0 and pulses cleared. A late mem_ack is ignored.
- rdata_out holds its last value between loads.

Decomposition:
- Shared package mem_align_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - state encodings ST_IDLE, ST_BUSY.
- One natural combinational sub-module, load_extend: inputs (word, addr[1:0], size, sign), output 32-bit extended value. It reuses the same sign/zero rule as the immediate extender.

Test Plan:
- Store byte d=0x000000A5 at addr 0x1003 → mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5; stall held until mem_ack, mem_req then drops.
- Load half addr 0x2002, sign=1, mem_rdata=0x8001_1234, ack after 2 wait cycles → stall for 3 cycles; rdata_out=0xFFFF8001, rdata_valid pulses once.
- Load byte addr 0x2001, sign=0, mem_rdata=0x0000_F000 → rdata_out=0x000000F0. Repeat with sign=1 → 0xFFFFFFF0.
- Word load at 0x3002 and size=11 at 0x3000 → misalign pulses one cycle each; mem_req never asserted; stall=0.
- Assert rst during BUSY, then mem_ack one cycle later → IDLE, mem_req=0, rdata_valid never pulses.
- Two consecutive word stores, ack in the first BUSY cycle each → second request accepted the cycle after the first ack; mem_be=1111 for both.
